// File: rtl/rom_stream_loader.sv
// rom_stream_loader: synchronous-read program memory with a run-time byte-stream loader.
// A host streams bytes (most significant byte of each word first). The loader packs them into
// words and writes addresses 0..len-1 in order. cpu_hold is kept high while a load is in flight
// so the CPU stays stalled until the new program is complete.
//
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready are both high.
// byte_ready is high only in LOAD. A byte offered while byte_ready is low is dropped, not buffered.
//
// dbg_state exposes the FSM encoding for checkers: IDLE=0, LOAD=1, DONE=2, ERR=3.
// DATA_W must be 8, 16, 24 or 32. READ_LAT must be 1 or 2.
module rom_stream_loader #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded,
    output logic [1:0]        dbg_state
);

    localparam int NB = DATA_W / 8;
    localparam logic [1:0] LAST_BYTE = 2'(NB - 1);
    // Number of words in the memory, expressed at load_len width.
    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t            state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   wr_cnt_q;     // write pointer; doubles as words_loaded
    logic [1:0]        byte_cnt_q;
    logic [DATA_W-1:0] asm_q;
    logic              byte_ready_q;
    logic              cpu_hold_q;
    logic              load_done_q;
    logic              load_err_q;

    logic              byte_acc;
    logic              word_last;
    logic [DATA_W-1:0] word_d;
    logic [ADDR_W:0]   wr_cnt_d;
    logic [ADDR_W-1:0] wr_addr;
    logic              len_bad;

    // Byte acceptance, word assembly and write-address decode.
    always_comb begin
        byte_acc  = (state_q == S_LOAD) && byte_valid && !load_abort;
        word_last = byte_acc && (byte_cnt_q == LAST_BYTE);
        word_d    = (asm_q << 8) | DATA_W'(byte_data);
        wr_cnt_d  = wr_cnt_q + 1'b1;
        wr_addr   = wr_cnt_q[ADDR_W-1:0];
        len_bad   = (load_len == '0) || (load_len > DEPTH_L);
    end

    // Loader FSM. All handshake and status outputs are registered with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            wr_cnt_q     <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            byte_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    load_done_q <= 1'b0;
                    load_err_q  <= 1'b0;
                    if (load_start) begin
                        wr_cnt_q   <= '0;
                        byte_cnt_q <= '0;
                        cpu_hold_q <= 1'b1;
                        if (len_bad) begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                        end else begin
                            state_q      <= S_LOAD;
                            len_q        <= load_len;
                            byte_ready_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    // Abort wins over a byte arriving on the same edge; a partial word is lost.
                    if (load_abort) begin
                        state_q      <= S_ERR;
                        byte_ready_q <= 1'b0;
                        load_err_q   <= 1'b1;
                    end else if (byte_acc) begin
                        asm_q <= word_d;
                        if (word_last) begin
                            byte_cnt_q <= '0;
                            wr_cnt_q   <= wr_cnt_d;
                            if (wr_cnt_d == len_q) begin
                                state_q      <= S_DONE;
                                byte_ready_q <= 1'b0;
                                load_done_q  <= 1'b1;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    load_done_q <= 1'b0;
                    cpu_hold_q  <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    load_err_q <= 1'b0;
                    cpu_hold_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (word_last) begin
            mem[wr_addr] <= word_d;
        end
    end

    logic [DATA_W-1:0] rd_data1_q;
    logic              rd_valid1_q;

    // First read stage: read-first, so a same-edge write is not visible here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data1_q  <= '0;
            rd_valid1_q <= 1'b0;
        end else begin
            rd_valid1_q <= rd_en;
            if (rd_en) begin
                rd_data1_q <= mem[rd_addr];
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd_data2_q;
            logic              rd_valid2_q;

            // Optional output register; data only moves when stage one is valid.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_data2_q  <= '0;
                    rd_valid2_q <= 1'b0;
                end else begin
                    rd_valid2_q <= rd_valid1_q;
                    if (rd_valid1_q) begin
                        rd_data2_q <= rd_data1_q;
                    end
                end
            end

            assign rd_data  = rd_data2_q;
            assign rd_valid = rd_valid2_q;
        end else begin : g_lat1
            assign rd_data  = rd_data1_q;
            assign rd_valid = rd_valid1_q;
        end
    endgenerate

    assign byte_ready   = byte_ready_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = wr_cnt_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rom_stream_loader.sv
// Bench for rom_stream_loader. Three instances share stimulus; sel picks which one sees
// load/byte/abort traffic and whose outputs are observed:
//   sel 0: ADDR_W=15 DATA_W=16 READ_LAT=1
//   sel 1: ADDR_W=4  DATA_W=16 READ_LAT=1
//   sel 2: ADDR_W=4  DATA_W=32 READ_LAT=2
// The reference memory is built from the byte stream: word w = bytes [w*NB .. w*NB+NB-1],
// most significant byte first, for every word the load completes.
module tb_rom_stream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic        load_start;
  logic [15:0] load_len;
  logic        load_abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  int          sel;

  logic [15:0] a_rd_data;  logic a_rd_valid, a_byte_ready, a_cpu_hold, a_done, a_err;
  logic [15:0] a_words;    logic [1:0] a_dbg;
  logic [15:0] b_rd_data;  logic b_rd_valid, b_byte_ready, b_cpu_hold, b_done, b_err;
  logic [4:0]  b_words;    logic [1:0] b_dbg;
  logic [31:0] c_rd_data;  logic c_rd_valid, c_byte_ready, c_cpu_hold, c_done, c_err;
  logic [4:0]  c_words;    logic [1:0] c_dbg;

  logic [31:0] m_rd_data;  logic m_rd_valid, m_byte_ready, m_cpu_hold, m_done, m_err;
  logic [15:0] m_words;    logic [1:0] m_dbg;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [int];
  logic [7:0]  stream [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  rom_stream_loader #(.ADDR_W(15), .DATA_W(16), .READ_LAT(1)) u_a (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .load_start(load_start && (sel == 0)), .load_len(load_len),
    .load_abort(load_abort && (sel == 0)), .byte_valid(byte_valid && (sel == 0)),
    .byte_data(byte_data), .byte_ready(a_byte_ready), .cpu_hold(a_cpu_hold),
    .load_done(a_done), .load_err(a_err), .words_loaded(a_words), .dbg_state(a_dbg));

  rom_stream_loader #(.ADDR_W(4), .DATA_W(16), .READ_LAT(1)) u_b (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr[3:0]),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .load_start(load_start && (sel == 1)), .load_len(load_len[4:0]),
    .load_abort(load_abort && (sel == 1)), .byte_valid(byte_valid && (sel == 1)),
    .byte_data(byte_data), .byte_ready(b_byte_ready), .cpu_hold(b_cpu_hold),
    .load_done(b_done), .load_err(b_err), .words_loaded(b_words), .dbg_state(b_dbg));

  rom_stream_loader #(.ADDR_W(4), .DATA_W(32), .READ_LAT(2)) u_c (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr[3:0]),
    .rd_data(c_rd_data), .rd_valid(c_rd_valid),
    .load_start(load_start && (sel == 2)), .load_len(load_len[4:0]),
    .load_abort(load_abort && (sel == 2)), .byte_valid(byte_valid && (sel == 2)),
    .byte_data(byte_data), .byte_ready(c_byte_ready), .cpu_hold(c_cpu_hold),
    .load_done(c_done), .load_err(c_err), .words_loaded(c_words), .dbg_state(c_dbg));

  // Observe the selected instance.
  always_comb begin
    m_rd_data = {16'h0, a_rd_data}; m_rd_valid = a_rd_valid; m_byte_ready = a_byte_ready;
    m_cpu_hold = a_cpu_hold; m_done = a_done; m_err = a_err; m_words = a_words; m_dbg = a_dbg;
    if (sel == 1) begin
      m_rd_data = {16'h0, b_rd_data}; m_rd_valid = b_rd_valid; m_byte_ready = b_byte_ready;
      m_cpu_hold = b_cpu_hold; m_done = b_done; m_err = b_err; m_words = {11'h0, b_words};
      m_dbg = b_dbg;
    end else if (sel == 2) begin
      m_rd_data = c_rd_data; m_rd_valid = c_rd_valid; m_byte_ready = c_byte_ready;
      m_cpu_hold = c_cpu_hold; m_done = c_done; m_err = c_err; m_words = {11'h0, c_words};
      m_dbg = c_dbg;
    end
  end

  // ---------------- reference model ----------------
  function automatic int key(input int s, input int a);
    return s * 65536 + a;
  endfunction

  function automatic int nb_of(input int s);
    return (s == 2) ? 4 : 2;
  endfunction

  function automatic int depth_of(input int s);
    return (s == 0) ? 32768 : 16;
  endfunction

  task automatic model_apply(input int nwords);
    int nb;
    logic [31:0] v;
    nb = nb_of(sel);
    for (int w = 0; w < nwords; w++) begin
      v = 32'h0;
      for (int k = 0; k < nb; k++) v = (v << 8) | {24'h0, stream[w * nb + k]};
      ref_mem[key(sel, w)] = v;
    end
  endtask

  task automatic fill_stream(input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- driver tasks ----------------
  // Runs one load on the selected instance using the bytes in stream.
  // abort_at >= 0: abort while presenting that byte. rf_idx >= 0: read rf_addr on the
  // edge that accepts byte rf_idx and expect the pre-load contents.
  task automatic run_load(input int len, input int max_gap, input int abort_at,
                          input int rf_idx, input int rf_addr);
    int nb, g;
    logic [31:0] rf_exp;
    nb = nb_of(sel);
    rf_exp = (rf_idx >= 0) ? ref_mem[key(sel, rf_addr)] : 32'h0;
    @(negedge clk);
    load_start = 1'b1;
    load_len = 16'(len);
    @(negedge clk);
    load_start = 1'b0;
    if (len == 0 || len > depth_of(sel)) begin
      n_vec++;
      if ({m_err, m_cpu_hold, m_byte_ready} !== 3'b110) begin
        n_bad++;
        $display("FAIL bad_len_err sel=%0d len=%0d got err/hold/ready=%b exp=110", sel, len,
                 {m_err, m_cpu_hold, m_byte_ready});
      end
      @(negedge clk);
      n_vec++;
      if ({m_err, m_cpu_hold} !== 2'b00) begin
        n_bad++;
        $display("FAIL bad_len_idle sel=%0d got err/hold=%b exp=00", sel, {m_err, m_cpu_hold});
      end
      return;
    end
    n_vec++;
    if ({m_byte_ready, m_cpu_hold, m_words} !== {2'b11, 16'h0}) begin
      n_bad++;
      $display("FAIL load_enter sel=%0d got ready/hold=%b words=%0d exp 11/0", sel,
               {m_byte_ready, m_cpu_hold}, m_words);
    end
    for (int i = 0; i < len * nb; i++) begin
      g = $urandom_range(0, max_gap);
      repeat (g) begin
        byte_valid = 1'b0;
        n_vec++;
        if (m_cpu_hold !== 1'b1) begin
          n_bad++;
          $display("FAIL hold_in_gap sel=%0d byte=%0d got=%b exp=1", sel, i, m_cpu_hold);
        end
        @(negedge clk);
      end
      if (i == abort_at) begin
        load_abort = 1'b1;
        byte_valid = 1'b1;
        byte_data = stream[i];
        @(negedge clk);
        load_abort = 1'b0;
        byte_valid = 1'b0;
        n_vec++;
        if ({m_err, m_done, m_byte_ready} !== 3'b100 || m_words !== 16'(abort_at / nb)) begin
          n_bad++;
          $display("FAIL abort sel=%0d got err/done/ready=%b words=%0d exp 100/%0d", sel,
                   {m_err, m_done, m_byte_ready}, m_words, abort_at / nb);
        end
        @(negedge clk);
        n_vec++;
        if ({m_err, m_cpu_hold} !== 2'b00) begin
          n_bad++;
          $display("FAIL abort_idle sel=%0d got err/hold=%b exp=00", sel, {m_err, m_cpu_hold});
        end
        model_apply(abort_at / nb);
        return;
      end
      byte_valid = 1'b1;
      byte_data = stream[i];
      // A load_start (with a bad length) inside LOAD must be ignored.
      if (i == 1) begin
        load_start = 1'b1;
        load_len = 16'h0;
      end
      if (i == rf_idx) begin
        rd_en = 1'b1;
        rd_addr = 15'(rf_addr);
      end
      @(negedge clk);
      byte_valid = 1'b0;
      load_start = 1'b0;
      rd_en = 1'b0;
      if (i == rf_idx) begin
        n_vec++;
        if (m_rd_valid !== 1'b1 || m_rd_data !== rf_exp) begin
          n_bad++;
          $display("FAIL read_first sel=%0d addr=%0d got v=%b d=%h exp v=1 d=%h", sel, rf_addr,
                   m_rd_valid, m_rd_data, rf_exp);
        end
      end
    end
    n_vec++;
    if ({m_done, m_err, m_cpu_hold, m_byte_ready} !== 4'b1010 || m_words !== 16'(len)) begin
      n_bad++;
      $display("FAIL load_done sel=%0d got done/err/hold/ready=%b words=%0d exp 1010/%0d", sel,
               {m_done, m_err, m_cpu_hold, m_byte_ready}, m_words, len);
    end
    @(negedge clk);
    n_vec++;
    if ({m_done, m_cpu_hold, m_byte_ready} !== 3'b000 || m_words !== 16'(len)) begin
      n_bad++;
      $display("FAIL load_idle sel=%0d got done/hold/ready=%b words=%0d exp 000/%0d", sel,
               {m_done, m_cpu_hold, m_byte_ready}, m_words, len);
    end
    model_apply(len);
  endtask

  // Single read with latency check, then check rd_valid falls while rd_data holds.
  task automatic do_read(input int addr);
    int lat;
    logic [31:0] exp;
    lat = (sel == 2) ? 2 : 1;
    exp = ref_mem[key(sel, addr)];
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = 15'(addr);
    @(negedge clk);
    rd_en = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) @(negedge clk);
      n_vec++;
      if (m_rd_valid !== ((c == lat) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL rd_valid_lat sel=%0d addr=%0d cycle=%0d got=%b", sel, addr, c, m_rd_valid);
      end
    end
    n_vec++;
    if (m_rd_data !== exp) begin
      n_bad++;
      $display("FAIL rd_data sel=%0d addr=%0d got=%h exp=%h", sel, addr, m_rd_data, exp);
    end
    @(negedge clk);
    n_vec++;
    if (m_rd_valid !== 1'b0 || m_rd_data !== exp) begin
      n_bad++;
      $display("FAIL rd_hold sel=%0d addr=%0d got v=%b d=%h exp v=0 d=%h", sel, addr,
               m_rd_valid, m_rd_data, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; rd_en = 1'b0; rd_addr = '0; load_start = 1'b0; load_len = '0;
    load_abort = 1'b0; byte_valid = 1'b0; byte_data = '0; sel = 0;
    #3;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_vec++;
      if ({m_rd_data, m_rd_valid, m_byte_ready, m_cpu_hold, m_done, m_err, m_words, m_dbg} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs sel=%0d got data=%h v=%b rdy=%b hold=%b words=%0d st=%0d exp 0",
                 s, m_rd_data, m_rd_valid, m_byte_ready, m_cpu_hold, m_words, m_dbg);
      end
    end
    sel = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load();
    sel = 0;
    stream = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    run_load(3, 0, -1, -1, 0);
    for (int a = 0; a < 3; a++) do_read(a);
  endtask

  task automatic test_stalls();
    sel = 0;
    fill_stream(6);
    run_load(3, 0, -1, -1, 0);
    stream = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    run_load(3, 5, -1, -1, 0);
    for (int a = 0; a < 3; a++) do_read(a);
  endtask

  task automatic test_random();
    int len;
    sel = 0;
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, 10);
      fill_stream(len * 2);
      run_load(len, 2, -1, -1, 0);
      for (int a = 0; a < len; a++) do_read(a);
    end
  endtask

  task automatic test_errors();
    sel = 0;
    run_load(0, 0, -1, -1, 0);
    do_read(0);
    fill_stream(10);
    run_load(5, 1, 3, -1, 0);
    do_read(0);
    do_read(1);
  endtask

  task automatic test_reset_midload();
    sel = 0;
    fill_stream(10);
    @(negedge clk);
    load_start = 1'b1;
    load_len = 16'd5;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1;
      byte_data = stream[i];
      @(negedge clk);
    end
    byte_valid = 1'b0;
    n_vec++;
    if ({m_cpu_hold, m_byte_ready} !== 2'b11 || m_words !== 16'd1) begin
      n_bad++;
      $display("FAIL pre_reset sel=0 got hold/ready=%b words=%0d exp 11/1",
               {m_cpu_hold, m_byte_ready}, m_words);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({m_rd_data, m_rd_valid, m_byte_ready, m_cpu_hold, m_done, m_err, m_words, m_dbg} !== '0) begin
      n_bad++;
      $display("FAIL async_reset sel=0 got data=%h rdy=%b hold=%b words=%0d st=%0d exp 0",
               m_rd_data, m_byte_ready, m_cpu_hold, m_words, m_dbg);
    end
    @(negedge clk);
    reset = 1'b0;
    model_apply(1);
    do_read(0);
    do_read(1);
  endtask

  task automatic test_boundary();
    sel = 1;
    fill_stream(32);
    run_load(16, 1, -1, -1, 0);
    do_read(15);
    do_read(7);
    do_read(0);
    run_load(17, 0, -1, -1, 0);
    do_read(15);
    fill_stream(32);
    run_load(16, 0, -1, 15, 7);
    do_read(7);
    do_read(15);
  endtask

  task automatic test_wide();
    sel = 2;
    stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    run_load(2, 1, -1, -1, 0);
    do_read(0);
    do_read(1);
    fill_stream(12);
    run_load(3, 2, -1, -1, 0);
    for (int a = 0; a < 3; a++) do_read(a);
  endtask

  initial begin
    test_reset();
    test_load();
    test_stalls();
    test_random();
    test_errors();
    test_reset_midload();
    test_boundary();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
